// File: rtl/ft232h_recv_data.sv
`default_nettype none
// ============================================================================
// Module   : ft232h_recv_data
// Purpose  : Receive-side controller for the FT232H synchronous 245 FIFO.
//            Drives OE#/RD#, samples ADBUS into a 4-entry skid buffer and
//            presents bytes on a ready/valid stream. Shares ADBUS with the
//            transmit path through tx_req_i / bus_own_o.
// Options  : FT_RX_STAT_EN - when defined, rx_cnt_o / burst_cnt_o count
//            captured bytes and completed bursts; otherwise both read 0.
// Revision : 1.0 - initial release
// ============================================================================
module ft232h_recv_data #(
  parameter int OE_LEAD   = 1,
  parameter int MAX_BURST = 512,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ft_rxf_i,
  input  logic [7:0]       ft_adbus_i,
  output logic             ft_oe_o,
  output logic             ft_rd_o,
  input  logic             tx_req_i,
  output logic             bus_own_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [CNT_W-1:0] rx_cnt_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  localparam int LEAD_W  = (OE_LEAD > 1) ? $clog2(OE_LEAD) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_READ    = 3'd2,
    S_DRAIN   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LEAD_W-1:0]  lead_q, lead_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W:0]   burst_inc;
  logic               oe_q, rd_q, own_q;
  logic               oe_d, rd_d, own_d;

  logic [7:0]         mem_q [4];
  logic [1:0]         head_q, tail_q;
  logic [2:0]         occ_q;

  logic               push, pop, space_ok, burst_full;

  // A byte is on ADBUS whenever RD# was low going into this edge and RXF# is low.
  assign push       = !rd_q && !ft_rxf_i;
  assign pop        = (occ_q != 3'd0) && rx_ready_i;
  // Occupancy as left by the last edge; with <=2 here, one more capture while
  // RD# is still low plus the capture on the edge RD# rises both fit.
  assign space_ok   = (occ_q <= 3'd2);
  assign burst_inc  = {1'b0, burst_q} + {{BURST_W{1'b0}}, push};
  assign burst_full = (burst_inc >= (BURST_W+1)'(MAX_BURST));

  assign rx_valid_o = (occ_q != 3'd0);
  assign rx_data_o  = rx_valid_o ? mem_q[head_q] : 8'h00;
  assign ft_oe_o    = oe_q;
  assign ft_rd_o    = rd_q;
  assign bus_own_o  = own_q;

  // Skid buffer data storage; contents are only observed through occupancy.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= ft_adbus_i;
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 3'd0;
    end else begin
      if (push) tail_q <= tail_q + 2'd1;
      if (pop)  head_q <= head_q + 2'd1;
      occ_q <= occ_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // State register and registered bus-control outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lead_q  <= '0;
      burst_q <= '0;
      oe_q    <= 1'b1;
      rd_q    <= 1'b1;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      burst_q <= burst_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
      own_q   <= own_d;
    end
  end

  // Next-state logic; bus outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    burst_d = push ? burst_inc[BURST_W-1:0] : burst_q;
    unique case (state_q)
      S_IDLE: begin
        lead_d  = '0;
        burst_d = '0;
        if (!ft_rxf_i && space_ok && !tx_req_i) state_d = S_TURN;
      end
      S_TURN: begin
        if (lead_q == LEAD_W'(OE_LEAD - 1)) begin
          state_d = ft_rxf_i ? S_RELEASE : S_READ;
        end else begin
          lead_d = lead_q + LEAD_W'(1);
        end
      end
      S_READ: begin
        if (ft_rxf_i || !space_ok || burst_full) state_d = S_DRAIN;
      end
      S_DRAIN:   state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    own_d = (state_d == S_TURN) || (state_d == S_READ) || (state_d == S_DRAIN);
    oe_d  = !own_d;
    rd_d  = (state_d != S_READ);
  end

`ifdef FT_RX_STAT_EN
  logic [CNT_W-1:0] rx_cnt_q, burst_cnt_q;

  // Statistics: bytes captured and bursts that captured at least one byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_cnt_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (push) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      if ((state_q == S_RELEASE) && (burst_q != '0)) burst_cnt_q <= burst_cnt_q + CNT_W'(1);
    end
  end

  assign rx_cnt_o    = rx_cnt_q;
  assign burst_cnt_o = burst_cnt_q;
`else
  assign rx_cnt_o    = '0;
  assign burst_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/ft232h_recv_data.md
Name: ft232h_recv_data

Overview:
- Receive-side controller for the FT232H synchronous 245 FIFO interface; reads host-to-FPGA bytes from the FT232H.
- Drives OE# and RD#, samples ADBUS, and buffers bytes in a 4-entry skid buffer.
- Presents bytes on a ready/valid stream to the command/config logic.
- Arbitrates bus ownership with the transmit path through tx_req_i / bus_own_o, so the shared ADBUS is driven by the FT232H only while this block owns it.

Parameters:
- OE_LEAD, default 1: cycles OE# is held low before RD# is first asserted (minimum 1).
- MAX_BURST, default 512: maximum bytes accepted per bus ownership before releasing the bus.
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk_i  in  1  60 MHz FT232H CLKOUT-derived clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ft_rxf_i  in  1  low = FT232H has data to read.
- ft_adbus_i  in  8  FT232H data bus (input direction).
- ft_oe_o  out  1  FT232H OE#, active low.
- ft_rd_o  out  1  FT232H RD#, active low.
- tx_req_i  in  1  transmit path requests the bus.
- bus_own_o  out  1  high while this block owns the bus; the transmit path must tristate ADBUS and hold WR# high.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  rx_data_o valid.
- rx_ready_i  in  1  downstream accepts the byte when valid and ready.
- rx_cnt_o  out  CNT_W  total bytes received, wrapping.
- burst_cnt_o  out  CNT_W  completed bursts, wrapping.

Behaviour:
- ft_oe_o, ft_rd_o and bus_own_o are registered outputs.
- Reset values:
  - ft_oe_o=1, ft_rd_o=1, bus_own_o=0, rx_valid_o=0, rx_data_o=0, counters=0.
  - Buffer empty; state IDLE.
  - Reset asserted mid-burst takes effect immediately (asynchronous); any partial buffer contents are discarded.
- Byte capture:
  - A byte is captured at a rising edge where registered ft_rd_o=0 and ft_rxf_i=0.
  - The byte is written into the buffer tail on that edge.
  - ADBUS is ignored at all other edges.
- Buffer:
  - 4 entries; the head drives rx_data_o/rx_valid_o with 0-cycle latency from occupancy.
  - Pop when rx_valid_o && rx_ready_i; push and pop in the same cycle are allowed, and occupancy is unchanged.
  - Space rule: next ft_rd_o may be 0 only if post-edge occupancy <= 2.
  - This rule ensures the byte captured on the edge where RD# rises still fits; overflow is impossible by design.
- IDLE:
  - OE#=1, RD#=1, bus_own_o=0.
  - Go to TURN when ft_rxf_i=0, occupancy <= 2 and tx_req_i=0.
- TURN:
  - OE#=0, RD#=1, bus_own_o=1; hold for OE_LEAD cycles.
  - Then go to READ if ft_rxf_i=0, else go to RELEASE.
- READ:
  - OE#=0, bus_own_o=1; RD#=0 while the space rule holds.
  - Track the burst byte count.
  - Go to DRAIN when any of these hold: ft_rxf_i sampled high, the space rule fails, or the burst count reaches MAX_BURST.
  - If several exit conditions coincide, take a single transition to DRAIN.
- DRAIN:
  - RD#=1, OE#=0 for 1 cycle; a byte captured on this edge is still accepted.
  - Then go to RELEASE.
- RELEASE:
  - OE#=1, bus_own_o=0 for 1 cycle.
  - burst_cnt_o increments if the burst captured ≥1 byte.
  - Then go to IDLE. IDLE re-enters TURN only when tx_req_i is low, so the transmit path gets priority after each burst.
- tx_req_i rising during TURN or READ does not abort; the burst ends through the normal READ exit conditions.
- Counters: rx_cnt_o increments per captured byte and wraps modulo 2^CNT_W.

Optional Feature:
- Macro FT_RX_STAT_EN.
- Defined: rx_cnt_o and burst_cnt_o are implemented as above.
- Undefined: both outputs are tied to 0 and the counter registers are not synthesized. Handshake behaviour is identical either way.

Test Plan:
- Reset, then ft_rxf_i=0 with rx_ready_i=1:
  - OE# falls 1 cycle after leaving IDLE; RD# falls OE_LEAD=1 cycle later.
  - Bytes 0x00..0x0F appear on rx_data_o in order; rx_cnt_o=16.
- ft_rxf_i=0 with rx_ready_i=0:
  - Exactly 4 bytes captured; RD# deasserts and no byte is lost.
  - Release rx_ready_i: bytes arrive in order and reading resumes.
- ft_rxf_i held low for 1000 bytes with MAX_BURST=512 and tx_req_i=1 from byte 100:
  - Bus is released after byte 512; state stays in IDLE while tx_req_i=1.
  - Drop tx_req_i: the remaining 488 bytes follow; burst_cnt_o=2.
- ft_rxf_i rises after 3 bytes while RD#=0:
  - State goes through DRAIN and RELEASE; exactly 3 bytes delivered; burst_cnt_o=1.
- Assert rst_i in the middle of READ:
  - Same cycle: OE#=1, RD#=1, rx_valid_o=0.
  - After reset is released, a new burst starts from an empty buffer.
- Build without FT_RX_STAT_EN: rx_cnt_o=burst_cnt_o=0 throughout scenario 1, and data matches.
